// File: rtl/vol_pkg.sv
// Shared types and constants for the volatility write-side feed.
// Holds the sequencer state encoding, the Q32.32 unit value and default index widths.
package vol_pkg;

    typedef enum logic {
        PASS  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [63:0] FP_ONE = 64'h1_0000_0000;

    localparam int NUM_STOCKS_DEF  = 4;
    localparam int BUFFER_SIZE_DEF = 32;
    localparam int STOCK_ID_W      = $clog2(NUM_STOCKS_DEF);
    localparam int PTR_W           = $clog2(BUFFER_SIZE_DEF);

endpackage

// File: rtl/volatility_feed_ctrl_recip_lut.sv
// Window-size reciprocal table: n (1..BUFFER_SIZE) -> floor(2^32/n) in Q32.32.
// Purely combinational, no backpressure; out-of-range n (including 0) yields 0.
module recip_lut
    import vol_pkg::*;
#(
    parameter int FP_WORD_SIZE = 64,
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_SIZE  = 32
) (
    input  logic [DATA_WIDTH-1:0]   n_i,
    output logic [FP_WORD_SIZE-1:0] recip_o
);

    logic [FP_WORD_SIZE-1:0] table_w [BUFFER_SIZE+1];

    for (genvar g = 0; g <= BUFFER_SIZE; g++) begin : g_tbl
        if (g == 0) begin : g_zero
            assign table_w[g] = '0;
        end else begin : g_val
            assign table_w[g] = FP_WORD_SIZE'(FP_ONE / 64'(g));
        end
    end

    always_comb begin
        recip_o = '0;
        for (int i = 1; i <= BUFFER_SIZE; i++) begin
            if (n_i == DATA_WIDTH'(i)) begin
                recip_o = table_w[i];
            end
        end
    end

endmodule

// File: rtl/volatility_feed_ctrl.sv
// Per-stock circular write sequencer for volatility_mem with a BUFFER_SIZE-cycle zero-fill flush.
// 1-cycle registered write per accepted update; o_ready drops while flushing or when a flush is requested.
module volatility_feed_ctrl
    import vol_pkg::*;
#(
    parameter int FP_WORD_SIZE = 64,
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_SIZE  = 32,
    parameter int NUM_STOCKS   = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [$clog2(NUM_STOCKS)-1:0]             i_stock_id,
    input  logic [DATA_WIDTH-1:0]                     i_best_bid,
    input  logic [DATA_WIDTH-1:0]                     i_best_ask,
    input  logic                                      i_flush,
    input  logic [$clog2(NUM_STOCKS)-1:0]             i_flush_stock_id,
    output logic                                      o_flush_busy,
    output logic                                      o_valid,
    output logic [$clog2(NUM_STOCKS*BUFFER_SIZE)-1:0] o_write_address,
    output logic [$clog2(NUM_STOCKS)-1:0]             o_stock_id,
    output logic [DATA_WIDTH-1:0]                     o_best_bid,
    output logic [DATA_WIDTH-1:0]                     o_best_ask,
    output logic [DATA_WIDTH-1:0]                     o_buffer_size,
    output logic [FP_WORD_SIZE-1:0]                   o_buffer_size_reciprocal,
    output logic                                      o_window_full
);

    localparam int SW = $clog2(NUM_STOCKS);
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int AW = SW + PW;
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    state_t                  state_q, state_d;
    logic [SW-1:0]           flush_id_q, flush_id_d;
    logic [PW-1:0]           k_q, k_d;
    logic [PW-1:0]           ptr_q [NUM_STOCKS];
    logic [PW-1:0]           ptr_d [NUM_STOCKS];
    logic [CW-1:0]           cnt_q [NUM_STOCKS];
    logic [CW-1:0]           cnt_d [NUM_STOCKS];
    logic [CW-1:0]           new_cnt;

    logic                    valid_q, valid_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [SW-1:0]           stock_q, stock_d;
    logic [DATA_WIDTH-1:0]   bid_q, bid_d;
    logic [DATA_WIDTH-1:0]   ask_q, ask_d;
    logic [DATA_WIDTH-1:0]   size_q, size_d;
    logic [FP_WORD_SIZE-1:0] recip_q, recip_d;
    logic                    full_q, full_d;

    assign o_ready      = (state_q == PASS) && !i_flush;
    assign o_flush_busy = (state_q == FLUSH);

    // Reciprocal is looked up on the next-state size so it registers alongside it.
    recip_lut #(
        .FP_WORD_SIZE (FP_WORD_SIZE),
        .DATA_WIDTH   (DATA_WIDTH),
        .BUFFER_SIZE  (BUFFER_SIZE)
    ) u_recip_lut (
        .n_i     (size_d),
        .recip_o (recip_d)
    );

    always_comb begin
        state_d    = state_q;
        flush_id_d = flush_id_q;
        k_d        = k_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        new_cnt    = '0;
        valid_d    = 1'b0;
        addr_d     = addr_q;
        stock_d    = stock_q;
        bid_d      = bid_q;
        ask_d      = ask_q;
        size_d     = size_q;
        full_d     = full_q;
        case (state_q)
            PASS: begin
                if (i_flush) begin
                    state_d    = FLUSH;
                    flush_id_d = i_flush_stock_id;
                    k_d        = '0;
                end else if (i_valid) begin
                    new_cnt = (cnt_q[i_stock_id] == CW'(BUFFER_SIZE)) ?
                              cnt_q[i_stock_id] : cnt_q[i_stock_id] + 1'b1;
                    ptr_d[i_stock_id] = ptr_q[i_stock_id] + 1'b1;
                    cnt_d[i_stock_id] = new_cnt;
                    valid_d = 1'b1;
                    addr_d  = {i_stock_id, ptr_q[i_stock_id]};
                    stock_d = i_stock_id;
                    bid_d   = i_best_bid;
                    ask_d   = i_best_ask;
                    size_d  = DATA_WIDTH'(new_cnt);
                    full_d  = (new_cnt == CW'(BUFFER_SIZE));
                end
            end
            FLUSH: begin
                valid_d = 1'b1;
                addr_d  = {flush_id_q, k_q};
                stock_d = flush_id_q;
                bid_d   = '0;
                ask_d   = '0;
                size_d  = DATA_WIDTH'(BUFFER_SIZE);
                full_d  = 1'b1;
                k_d     = k_q + 1'b1;
                if (k_q == PW'(BUFFER_SIZE - 1)) begin
                    ptr_d[flush_id_q] = '0;
                    cnt_d[flush_id_q] = '0;
                    state_d           = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= PASS;
            flush_id_q <= '0;
            k_q        <= '0;
            for (int i = 0; i < NUM_STOCKS; i++) begin
                ptr_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            valid_q <= 1'b0;
            addr_q  <= '0;
            stock_q <= '0;
            bid_q   <= '0;
            ask_q   <= '0;
            size_q  <= '0;
            recip_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flush_id_q <= flush_id_d;
            k_q        <= k_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            addr_q     <= addr_d;
            stock_q    <= stock_d;
            bid_q      <= bid_d;
            ask_q      <= ask_d;
            size_q     <= size_d;
            recip_q    <= recip_d;
            full_q     <= full_d;
        end
    end

    assign o_valid                  = valid_q;
    assign o_write_address          = addr_q;
    assign o_stock_id               = stock_q;
    assign o_best_bid               = bid_q;
    assign o_best_ask               = ask_q;
    assign o_buffer_size            = size_q;
    assign o_buffer_size_reciprocal = recip_q;
    assign o_window_full            = full_q;

endmodule
